iic_reg_sequencer: RTL and testbench
====================================

# iic_reg_sequencer

Register-level front end for the IIC byte-operation engine in the KAT ADC IIC controller. It accepts one register request at a time: device address, register address, 1 or 2 data bytes, read or write. It expands the request into the ordered sequence of byte operations, including START, repeated START, STOP and lock, and presents them on the op interface that feeds the controller's arbiter. It returns read data, error status and a completion pulse to fabric logic, such as the gain loader, so that fabric no longer has to build op words by hand.

## Interface
Parameters:
- ACK_TIMEOUT, 1000000: max wb_clk_i cycles an op may wait for op_ack; 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_rnw  in  1  1 = register read, 0 = register write
- req_two_byte  in  1  1 = 16-bit data, 0 = 8-bit data
- req_dev_addr  in  7  IIC 7-bit device address
- req_reg_addr  in  8  register address byte
- req_wr_data  in  16  write data; bits [7:0] used when req_two_byte=0
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rd_data  out  16  read data, MSB byte first on the bus; upper byte 0 for 1-byte reads
- rsp_err  out  1  any op returned op_err, or a timeout occurred; qualified by rsp_valid
- rsp_timeout  out  1  timeout abort; qualified by rsp_valid
- op_valid  out  1  op presented to the arbiter/engine
- op_start  out  1  issue START (or repeated START) before the byte
- op_stop  out  1  issue STOP after the byte
- op_rnw  out  1  byte is read from the slave
- op_lock  out  1  hold arbiter ownership after this op
- op_wr_data  out  8  byte to transmit
- op_ack  in  1  one-cycle pulse: current op finished
- op_err  in  1  NACK/bus error, valid with op_ack
- op_rd_data  in  8  received byte, valid with op_ack

## Operation
- States: IDLE, DEV_W, REG, WD_HI, WD_LO, DEV_R, RD_HI, RD_LO, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields, clear the error/data accumulators, go to DEV_W.
- DEV_W: start=1, wr_data={dev,1'b0}, rnw=0.
- REG: wr_data=reg_addr.
- Write path:
  - REG → WD_HI if two-byte, else WD_LO.
  - WD_HI = wr_data[15:8].
  - WD_LO = wr_data[7:0], stop=1.
- Read path:
  - REG → DEV_R: start=1, wr_data={dev,1'b1}.
  - DEV_R → RD_HI if two-byte, else RD_LO.
  - RD_HI: op_rnw=1; op_rd_data → rsp_rd_data[15:8].
  - RD_LO: op_rnw=1, stop=1; op_rd_data → rsp_rd_data[7:0].
- op_lock=1 on every op except the final STOP op, so the transaction is atomic at the arbiter.
- State advances only on op_ack.
- op_err is OR-accumulated into the error flag. The sequence still runs to completion so that the bus always receives a STOP; bytes written after an error are unchanged.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_rd_data/rsp_err/rsp_timeout stable.
  - Then IDLE.
- rsp_rd_data, rsp_err and rsp_timeout hold their values until the next request is accepted.
- Timeout:
  - A counter clears on every new op and on op_ack, and counts while op_valid=1 and op_ack=0.
  - When it reaches ACK_TIMEOUT (ACK_TIMEOUT≠0): op_valid drops, rsp_err=1, rsp_timeout=1, go to RESP.

## Timing
- All outputs are registered.
- Reset values: op_valid=0, op_start/stop/rnw/lock=0, op_wr_data=0, rsp_valid=0, rsp_rd_data=0, rsp_err=0, rsp_timeout=0, req_ready=0 during reset and 1 the cycle after reset deasserts.
- Request accepted on the edge where req_valid && req_ready. op_valid rises the next cycle with DEV_W fields.
- Op handshake:
  - Op fields are constant while op_valid=1.
  - On the op_ack edge, the next op's fields load and op_valid stays high (back-to-back, matching FIFO-style first-word-fall-through consumers).
  - After the final op's ack, op_valid=0 and rsp_valid=1 on the next cycle.
- op_ack while op_valid=0 is ignored.
- Op counts: a write is 3 or 4 ops; a read is 4 or 5 ops.
- Minimum request-to-rsp_valid latency is N_ops+1 cycles.
- A new request can be accepted the cycle after rsp_valid.
- wb_rst_i mid-transaction: all state returns to IDLE and op_valid drops immediately. No STOP is generated; bus recovery belongs to the engine's reset.
- Timeout counter width: 32 bits. Expiry is exact at ACK_TIMEOUT cycles after op_valid assertion without op_ack.

## Structure
- Shared package kat_adc_iic_pkg holds:
  - the state enum;
  - the 12-bit op-word bit positions (LOCK=11, STOP=10, START=9, RNW=8, DATA=7:0), shared with the op FIFOs;
  - IIC_RD=1'b1 and IIC_WR=1'b0.
- One sub-module, iic_ack_timer: loadable-clear cycle counter with an expire output, parameterised by ACK_TIMEOUT.
- The main FSM stays in iic_reg_sequencer.

## Test plan
- Write, 1 byte:
  - Stimulus: dev=0x21, reg=0x05, data=0x00A7; auto-ack bench.
  - Required ops: {start,0x42,lock}, {0x05,lock}, {0xA7,stop,lock=0}.
  - Required response: rsp_valid one cycle, rsp_err=0.
- Read, 2 byte:
  - Stimulus: dev=0x21, reg=0x10; bench returns 0x12 then 0x34.
  - Required ops: 0x42, 0x10, {start,0x43}, rnw, {rnw,stop}.
  - Required response: rsp_rd_data=0x1234.
- NACK:
  - Stimulus: op_err with the DEV_W ack of a 2-byte write.
  - Required: all 4 ops still issued, the last with stop; rsp_err=1, rsp_timeout=0.
- Timeout:
  - Stimulus: ACK_TIMEOUT=16; withhold op_ack on REG.
  - Required: op_valid falls exactly 16 cycles after REG is presented; rsp_err=1, rsp_timeout=1.
- Reset mid-read:
  - Stimulus: assert wb_rst_i during DEV_R.
  - Required: next cycle op_valid=0 and rsp_valid=0; after release, a fresh write completes normally.
- Back-to-back:
  - Stimulus: req_valid held high for two requests.
  - Required: second accepted the cycle after the first rsp_valid; op_ack ignored while idle.

Source files
------------

// File: rtl/kat_adc_iic_pkg.sv
// Shared definitions for the KAT ADC IIC controller: sequencer states,
// op-word bit layout used by the op FIFOs, and IIC direction bits.
package kat_adc_iic_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_DEV_W = 4'd1,
      ST_REG   = 4'd2,
      ST_WD_HI = 4'd3,
      ST_WD_LO = 4'd4,
      ST_DEV_R = 4'd5,
      ST_RD_HI = 4'd6,
      ST_RD_LO = 4'd7,
      ST_RESP  = 4'd8
   } seq_state_t;

   localparam int OP_WIDTH   = 12;
   localparam int OP_LOCK    = 11;
   localparam int OP_STOP    = 10;
   localparam int OP_START   = 9;
   localparam int OP_RNW     = 8;
   localparam int OP_DATA_HI = 7;
   localparam int OP_DATA_LO = 0;

   localparam logic IIC_RD = 1'b1;
   localparam logic IIC_WR = 1'b0;

   function automatic logic [OP_WIDTH-1:0] make_op(input logic lock, input logic stop,
                                                   input logic start, input logic rnw,
                                                   input logic [7:0] data);
      logic [OP_WIDTH-1:0] w;
      w                       = '0;
      w[OP_LOCK]              = lock;
      w[OP_STOP]              = stop;
      w[OP_START]             = start;
      w[OP_RNW]               = rnw;
      w[OP_DATA_HI:OP_DATA_LO] = data;
      return w;
   endfunction

endpackage

// File: rtl/iic_ack_timer.sv
// Cycle counter that flags when an op has waited ACK_TIMEOUT cycles for its ack.
// ACK_TIMEOUT of zero disables expiry entirely.
module iic_ack_timer #(
   parameter int unsigned ACK_TIMEOUT = 1000000
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic clear,
   input  logic count_en,
   output logic expire
);

   localparam logic [31:0] LAST = 32'(ACK_TIMEOUT) - 32'd1;

   logic [31:0] count;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clear)
         count <= '0;
      else if (count_en)
         count <= count + 32'd1;
   end

   // Fires during the ACK_TIMEOUT-th waiting cycle so the abort lands exactly on that edge
   assign expire = (ACK_TIMEOUT != 0) && count_en && (count == LAST);

endmodule

// File: rtl/iic_reg_sequencer.sv
// Expands one IIC register read/write request into the ordered byte-op sequence
// for the engine arbiter, and returns read data, error status and a done pulse.
module iic_reg_sequencer
   import kat_adc_iic_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 1000000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rnw,
   input  logic        req_two_byte,
   input  logic [6:0]  req_dev_addr,
   input  logic [7:0]  req_reg_addr,
   input  logic [15:0] req_wr_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_rd_data,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        op_valid,
   output logic        op_start,
   output logic        op_stop,
   output logic        op_rnw,
   output logic        op_lock,
   output logic [7:0]  op_wr_data,
   input  logic        op_ack,
   input  logic        op_err,
   input  logic [7:0]  op_rd_data
);

   seq_state_t          state;
   seq_state_t          after_ack;
   logic                rnw_q;
   logic                two_q;
   logic [6:0]          dev_q;
   logic [7:0]          reg_q;
   logic [15:0]         wd_q;
   logic [OP_WIDTH-1:0] op_word;
   logic                accept;
   logic                op_done;
   logic                expire;

   function automatic seq_state_t next_op_state(input seq_state_t s, input logic rnw,
                                                input logic two);
      case (s)
         ST_DEV_W: return ST_REG;
         ST_REG:   return rnw ? ST_DEV_R : (two ? ST_WD_HI : ST_WD_LO);
         ST_WD_HI: return ST_WD_LO;
         ST_DEV_R: return two ? ST_RD_HI : ST_RD_LO;
         ST_RD_HI: return ST_RD_LO;
         default:  return ST_RESP;
      endcase
   endfunction

   // Only the last op of a transaction releases the arbiter lock, together with STOP
   function automatic logic [OP_WIDTH-1:0] op_for_state(input seq_state_t s,
                                                        input logic [6:0] dev,
                                                        input logic [7:0] rg,
                                                        input logic [15:0] wd);
      case (s)
         ST_DEV_W: return make_op(1'b1, 1'b0, 1'b1, 1'b0, {dev, IIC_WR});
         ST_REG:   return make_op(1'b1, 1'b0, 1'b0, 1'b0, rg);
         ST_WD_HI: return make_op(1'b1, 1'b0, 1'b0, 1'b0, wd[15:8]);
         ST_WD_LO: return make_op(1'b0, 1'b1, 1'b0, 1'b0, wd[7:0]);
         ST_DEV_R: return make_op(1'b1, 1'b0, 1'b1, 1'b0, {dev, IIC_RD});
         ST_RD_HI: return make_op(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
         ST_RD_LO: return make_op(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
         default:  return '0;
      endcase
   endfunction

   assign accept    = (state == ST_IDLE) && req_valid && req_ready;
   assign op_done   = op_valid && op_ack;
   assign after_ack = next_op_state(state, rnw_q, two_q);

   iic_ack_timer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timer (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .clear    (accept || op_ack),
      .count_en (op_valid && !op_ack),
      .expire   (expire)
   );

   assign op_lock    = op_word[OP_LOCK];
   assign op_stop    = op_word[OP_STOP];
   assign op_start   = op_word[OP_START];
   assign op_rnw     = op_word[OP_RNW];
   assign op_wr_data = op_word[OP_DATA_HI:OP_DATA_LO];

   // Errors accumulate but never cut the sequence short, so the bus always sees a STOP
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= ST_IDLE;
         req_ready   <= 1'b0;
         op_valid    <= 1'b0;
         op_word     <= '0;
         rsp_valid   <= 1'b0;
         rsp_rd_data <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         rnw_q       <= 1'b0;
         two_q       <= 1'b0;
         dev_q       <= '0;
         reg_q       <= '0;
         wd_q        <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rnw_q       <= req_rnw;
                  two_q       <= req_two_byte;
                  dev_q       <= req_dev_addr;
                  reg_q       <= req_reg_addr;
                  wd_q        <= req_wr_data;
                  rsp_rd_data <= '0;
                  rsp_err     <= 1'b0;
                  rsp_timeout <= 1'b0;
                  req_ready   <= 1'b0;
                  op_valid    <= 1'b1;
                  op_word     <= op_for_state(ST_DEV_W, req_dev_addr, req_reg_addr,
                                              req_wr_data);
                  state       <= ST_DEV_W;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ST_RESP: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               if (expire) begin
                  op_valid    <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  state       <= ST_RESP;
               end else if (op_done) begin
                  rsp_err <= rsp_err | op_err;
                  if (state == ST_RD_HI)
                     rsp_rd_data[15:8] <= op_rd_data;
                  if (state == ST_RD_LO)
                     rsp_rd_data[7:0] <= op_rd_data;
                  state <= after_ack;
                  if (after_ack == ST_RESP) begin
                     op_valid  <= 1'b0;
                     rsp_valid <= 1'b1;
                  end else begin
                     op_word <= op_for_state(after_ack, dev_q, reg_q, wd_q);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iic_reg_sequencer.sv
// Randomised bench for iic_reg_sequencer: a bench-side engine acks ops with random
// latency while a queue-based model predicts the op list and the response.
module tb_iic_reg_sequencer;

   localparam int TO = 16;

   typedef struct packed {
      logic        rnw;
      logic        two;
      logic [6:0]  dev;
      logic [7:0]  rg;
      logic [15:0] wd;
   } req_t;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_rnw = 1'b0;
   logic        req_two_byte = 1'b0;
   logic [6:0]  req_dev_addr = '0;
   logic [7:0]  req_reg_addr = '0;
   logic [15:0] req_wr_data = '0;
   logic        rsp_valid;
   logic [15:0] rsp_rd_data;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        op_valid;
   logic        op_start;
   logic        op_stop;
   logic        op_rnw;
   logic        op_lock;
   logic [7:0]  op_wr_data;
   logic        op_ack = 1'b0;
   logic        op_err = 1'b0;
   logic [7:0]  op_rd_data = '0;

   int          total = 0;
   int          bad = 0;
   bit          presented = 1'b0;
   logic [11:0] exp_ops[$];

   iic_reg_sequencer #(.ACK_TIMEOUT(TO)) dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_i     (wb_rst_i),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rnw      (req_rnw),
      .req_two_byte (req_two_byte),
      .req_dev_addr (req_dev_addr),
      .req_reg_addr (req_reg_addr),
      .req_wr_data  (req_wr_data),
      .rsp_valid    (rsp_valid),
      .rsp_rd_data  (rsp_rd_data),
      .rsp_err      (rsp_err),
      .rsp_timeout  (rsp_timeout),
      .op_valid     (op_valid),
      .op_start     (op_start),
      .op_stop      (op_stop),
      .op_rnw       (op_rnw),
      .op_lock      (op_lock),
      .op_wr_data   (op_wr_data),
      .op_ack       (op_ack),
      .op_err       (op_err),
      .op_rd_data   (op_rd_data)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic req_t mk_req(input logic rnw, input logic two, input logic [6:0] dev,
                                   input logic [7:0] rg, input logic [15:0] wd);
      req_t r;
      r.rnw = rnw; r.two = two; r.dev = dev; r.rg = rg; r.wd = wd;
      return r;
   endfunction

   // Expected op words as {lock, stop, start, rnw, byte}; read ops carry no byte
   function automatic logic [11:0] op_w(input bit lock, input bit stop, input bit start,
                                        input bit rnw, input int data);
      return {lock, stop, start, rnw, 8'(data)};
   endfunction

   function automatic void model_ops(input req_t r);
      exp_ops.delete();
      exp_ops.push_back(op_w(1, 0, 1, 0, r.dev * 2));
      exp_ops.push_back(op_w(1, 0, 0, 0, r.rg));
      if (r.rnw) begin
         exp_ops.push_back(op_w(1, 0, 1, 0, r.dev * 2 + 1));
         if (r.two) exp_ops.push_back(op_w(1, 0, 0, 1, 0));
         exp_ops.push_back(op_w(0, 1, 0, 1, 0));
      end else begin
         if (r.two) exp_ops.push_back(op_w(1, 0, 0, 0, r.wd / 256));
         exp_ops.push_back(op_w(0, 1, 0, 0, r.wd % 256));
      end
   endfunction

   function automatic logic [11:0] obs_word();
      return {op_lock, op_stop, op_start, op_rnw, (op_rnw ? 8'h00 : op_wr_data)};
   endfunction

   task automatic drive_req(input req_t r);
      req_valid    = 1'b1;
      req_rnw      = r.rnw;
      req_two_byte = r.two;
      req_dev_addr = r.dev;
      req_reg_addr = r.rg;
      req_wr_data  = r.wd;
   endtask

   // One full request: err_idx injects op_err on that op's ack, hold_idx withholds that
   // op's ack, abort_idx asserts reset when that op appears; -1 disables each
   task automatic applyStimulus(input req_t r, input int exp_wait, input bit chain_next,
                                input req_t nxt, input int err_idx, input int hold_idx,
                                input int abort_idx);
      int          waited, cyc, idx, delay, held_cycles, n_seen;
      bit          done, fresh, exp_err;
      logic [15:0] exp_rd;
      logic [7:0]  b;
      model_ops(r);
      if (!presented) drive_req(r);
      presented = 1'b0;
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(negedge wb_clk_i);
         waited++;
      end
      if (!req_ready) begin
         checkOutput("req_ready_wait", 0, 1);
         req_valid = 1'b0;
         return;
      end
      if (exp_wait >= 0) checkOutput("accept_wait", waited, exp_wait);
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      if (!chain_next) req_valid = 1'b0;
      checkOutput("op_valid_rise", op_valid, 1);

      idx = 0; cyc = 0; done = 0; fresh = 1; exp_err = 0; exp_rd = '0;
      held_cycles = 0; delay = 0;
      while (!done && cyc < 400) begin
         op_ack = 1'b0;
         op_err = 1'b0;
         op_rd_data = 8'($urandom);
         if (rsp_valid) begin
            done = 1;
         end else if (op_valid) begin
            if (fresh) begin
               if (idx < exp_ops.size())
                  checkOutput($sformatf("op%0d", idx), obs_word(), exp_ops[idx]);
               else
                  checkOutput("extra_op", idx, exp_ops.size());
               if (idx == abort_idx) begin
                  wb_rst_i  = 1'b1;
                  req_valid = 1'b0;
                  @(negedge wb_clk_i);
                  checkOutput("rst_op_valid", op_valid, 0);
                  checkOutput("rst_rsp_valid", rsp_valid, 0);
                  checkOutput("rst_req_ready", req_ready, 0);
                  wb_rst_i = 1'b0;
                  return;
               end
               fresh = 0;
               delay = $urandom_range(0, 3);
            end
            if (idx == hold_idx) begin
               held_cycles++;
            end else if (delay == 0) begin
               b          = 8'($urandom);
               op_ack     = 1'b1;
               op_rd_data = b;
               op_err     = (idx == err_idx);
               exp_err    = exp_err | (idx == err_idx);
               if (idx < exp_ops.size() && exp_ops[idx][8])
                  exp_rd = {exp_rd[7:0], b};
               idx++;
               fresh = 1;
            end else begin
               delay--;
            end
         end
         if (!done) begin
            @(negedge wb_clk_i);
            cyc++;
         end
      end
      op_ack = 1'b0;
      op_err = 1'b0;
      if (!done) begin
         checkOutput("rsp_valid_wait", 0, 1);
         return;
      end
      n_seen = idx + ((hold_idx >= 0) ? 1 : 0);
      checkOutput("op_count", n_seen, (hold_idx >= 0) ? hold_idx + 1 : exp_ops.size());
      checkOutput("rsp_op_valid", op_valid, 0);
      checkOutput("rsp_rd_data", rsp_rd_data, exp_rd);
      checkOutput("rsp_err", rsp_err, exp_err || (hold_idx >= 0));
      checkOutput("rsp_timeout", rsp_timeout, hold_idx >= 0);
      if (hold_idx >= 0) checkOutput("timeout_cycles", held_cycles, TO);
      if (chain_next) begin
         drive_req(nxt);
         presented = 1'b1;
         return;
      end
      @(negedge wb_clk_i);
      checkOutput("rsp_pulse_len", rsp_valid, 0);
      checkOutput("ready_after_rsp", req_ready, 1);
      checkOutput("rsp_hold", rsp_rd_data, exp_rd);
   endtask

   initial begin
      req_t none, r2;
      none = mk_req(0, 0, 7'h0, 8'h0, 16'h0);
      repeat (3) @(negedge wb_clk_i);
      checkOutput("reset_op_valid", op_valid, 0);
      checkOutput("reset_op_fields", {op_start, op_stop, op_rnw, op_lock, op_wr_data}, 0);
      checkOutput("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rd_data}, 0);
      checkOutput("reset_req_ready", req_ready, 0);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      checkOutput("ready_after_reset", req_ready, 1);

      $display("[TB] write 1 byte");
      applyStimulus(mk_req(0, 0, 7'h21, 8'h05, 16'h00A7), 0, 0, none, -1, -1, -1);
      $display("[TB] read 2 byte");
      applyStimulus(mk_req(1, 1, 7'h21, 8'h10, 16'h0000), 0, 0, none, -1, -1, -1);
      $display("[TB] nack on device address");
      applyStimulus(mk_req(0, 1, 7'h21, 8'h33, 16'hBEEF), 0, 0, none, 0, -1, -1);
      $display("[TB] ack timeout on register op");
      applyStimulus(mk_req(0, 1, 7'h2C, 8'h44, 16'h1357), 0, 0, none, -1, 1, -1);
      $display("[TB] reset during DEV_R");
      applyStimulus(mk_req(1, 1, 7'h21, 8'h10, 16'h0000), 0, 0, none, -1, -1, 2);
      applyStimulus(mk_req(0, 0, 7'h50, 8'hA0, 16'h005A), -1, 0, none, -1, -1, -1);

      $display("[TB] op_ack while idle");
      for (int i = 0; i < 3; i++) begin
         op_ack = 1'b1;
         op_err = 1'b1;
         @(negedge wb_clk_i);
         checkOutput("idle_ack_op_valid", op_valid, 0);
      end
      op_ack = 1'b0;
      op_err = 1'b0;
      applyStimulus(mk_req(0, 1, 7'h11, 8'h22, 16'hC3A5), 0, 0, none, -1, -1, -1);

      $display("[TB] back-to-back requests");
      r2 = mk_req(1, 0, 7'h3A, 8'h7E, 16'h0000);
      applyStimulus(mk_req(0, 1, 7'h12, 8'h34, 16'h5678), 0, 1, r2, -1, -1, -1);
      applyStimulus(r2, 1, 0, none, -1, -1, -1);

      $display("[TB] random requests");
      for (int n = 0; n < 24; n++) begin
         req_t rr;
         int   e;
         rr = mk_req(1'($urandom), 1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom));
         e  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
         applyStimulus(rr, 0, 0, none, e, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
